// File: rtl/fetch_unit.sv
// Instruction-fetch stage for the single-cycle 9-bit core: owns the PC and the jump-target LUT,
// presents the current instruction to control and frames each run with a start/done handshake.
module fetch_unit #(
    parameter int          PC_W      = 10,
    parameter logic [8:0]  HALT_WORD = 9'h1FF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [8:0]      instr_in,
    input  logic            pc_jmp_en,
    input  logic            pc_jmp_abs,
    input  logic [3:0]      lut_ptr,
    input  logic            lut_wr_en,
    input  logic [3:0]      lut_wr_addr,
    input  logic [PC_W-1:0] lut_wr_data,
    output logic [PC_W-1:0] pc_out,
    output logic [8:0]      instr_out,
    output logic            fetch_valid,
    output logic            done,
    output logic [15:0]     cycle_cnt,
    output logic [1:0]      fsm_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [PC_W-1:0] PC_ONE  = PC_W'(1);
    localparam logic [15:0]     CNT_MAX = 16'hFFFF;

    state_t          state;
    state_t          state_nxt;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_nxt;
    logic [15:0]     cnt;
    logic [15:0]     cnt_nxt;

    logic [PC_W-1:0] lut [16];
    logic [PC_W-1:0] lut_val;
    logic [PC_W-1:0] jmp_target;
    logic            is_halt;
    logic            exec;

    // Handshake: start is a level sampled at a rising edge while in IDLE or DONE only;
    // fetch_valid qualifies instr_out for the cycle in which it is high, with no back-pressure.

    // LUT reads see the register contents, so a same-edge write is visible only next cycle.
    assign lut_val    = lut[lut_ptr];
    assign is_halt    = (instr_in == HALT_WORD);
    assign exec       = (state == ST_RUN) && !is_halt;
    // Relative targets are PC_W-bit two's complement; the truncating add wraps backward branches.
    assign jmp_target = pc_jmp_abs ? lut_val : (pc + lut_val);

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                pc_nxt = '0;
                if (start) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = '0;
                end
            end
            ST_RUN: begin
                if (is_halt) begin
                    state_nxt = ST_DONE;
                end else begin
                    pc_nxt = pc_jmp_en ? jmp_target : (pc + PC_ONE);
                    if (cnt != CNT_MAX) begin
                        cnt_nxt = cnt + 16'd1;
                    end
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_nxt = ST_RUN;
                    pc_nxt    = '0;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                pc_nxt    = '0;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            pc    <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                lut[i] <= '0;
            end
        end else if (lut_wr_en) begin
            lut[lut_wr_addr] <= lut_wr_data;
        end
    end

    assign pc_out      = pc;
    assign fetch_valid = exec;
    assign instr_out   = exec ? instr_in : 9'h000;
    assign done        = (state == ST_DONE);
    assign cycle_cnt   = cnt;
    assign fsm_state   = state;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: bench-owned ROM and a small control stand-in, a behavioural model
// compared every cycle, plus literal checks for the directed program scenarios.
module tb_fetch_unit;

    localparam logic [8:0] HALT = 9'h1FF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [8:0]  instr_in;
    logic        pc_jmp_en;
    logic        pc_jmp_abs;
    logic [3:0]  lut_ptr;
    logic        lut_wr_en = 1'b0;
    logic [3:0]  lut_wr_addr = 4'd0;
    logic [9:0]  lut_wr_data = 10'd0;
    logic [9:0]  pc_out;
    logic [8:0]  instr_out;
    logic        fetch_valid;
    logic        done;
    logic [15:0] cycle_cnt;
    logic [1:0]  fsm_state;

    fetch_unit #(.PC_W(10), .HALT_WORD(9'h1FF)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .instr_in(instr_in),
        .pc_jmp_en(pc_jmp_en), .pc_jmp_abs(pc_jmp_abs), .lut_ptr(lut_ptr),
        .lut_wr_en(lut_wr_en), .lut_wr_addr(lut_wr_addr), .lut_wr_data(lut_wr_data),
        .pc_out(pc_out), .instr_out(instr_out), .fetch_valid(fetch_valid),
        .done(done), .cycle_cnt(cycle_cnt), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic cmp_en = 1'b0;
    logic trace_en = 1'b0;
    int trace[$];

    // ROM and control stand-in. Encoding: [8:6]=100 abs jump, 101 rel jump,
    // 110 rel branch taken while br_cnt < loop_limit; [3:0] = LUT pointer.
    logic [8:0] rom [1024];
    int   loop_limit = 0;
    int   br_cnt = 0;
    logic force_halt_jmp = 1'b0;

    function automatic logic [5:0] ctl(logic [8:0] w, int brc, int lim, logic fh);
        logic en;
        logic ab;
        en = (w[8:6] == 3'b100) || (w[8:6] == 3'b101) ||
             ((w[8:6] == 3'b110) && (brc < lim)) || (fh && (w == HALT));
        ab = (w[8:6] == 3'b100) || (fh && (w == HALT));
        return {en, ab, w[3:0]};
    endfunction

    assign instr_in = rom[pc_out];
    assign {pc_jmp_en, pc_jmp_abs, lut_ptr} = ctl(instr_in, br_cnt, loop_limit, force_halt_jmp);

    always @(posedge clk) begin
        if (start) br_cnt <= 0;
        else if (fetch_valid && instr_in[8:6] == 3'b110 && br_cnt < loop_limit) br_cnt <= br_cnt + 1;
    end

    // Behavioural model
    logic m_running = 1'b0;
    logic m_done = 1'b0;
    int   m_pc = 0;
    int   m_cnt = 0;
    int   m_lut [16];
    wire [5:0] m_ctl = ctl(rom[m_pc], br_cnt, loop_limit, force_halt_jmp);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_running <= 1'b0;
            m_done    <= 1'b0;
            m_pc      <= 0;
            m_cnt     <= 0;
            for (int i = 0; i < 16; i++) m_lut[i] <= 0;
        end else begin
            if (m_running) begin
                if (rom[m_pc] == HALT) begin
                    m_running <= 1'b0;
                    m_done    <= 1'b1;
                end else begin
                    m_cnt <= m_cnt + 1;
                    if (m_ctl[5])
                        m_pc <= m_ctl[4] ? m_lut[m_ctl[3:0]] : (m_pc + m_lut[m_ctl[3:0]]) % 1024;
                    else
                        m_pc <= (m_pc + 1) % 1024;
                end
            end else if (start) begin
                m_running <= 1'b1;
                m_done    <= 1'b0;
                m_pc      <= 0;
                m_cnt     <= 0;
            end
            if (lut_wr_en) m_lut[lut_wr_addr] <= int'(lut_wr_data);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            logic exp_fv;
            exp_fv = m_running && (rom[m_pc] != HALT);
            chk("pc_out", int'(pc_out), m_pc);
            chk("done", int'(done), int'(m_done));
            chk("fetch_valid", int'(fetch_valid), int'(exp_fv));
            chk("instr_out", int'(instr_out), exp_fv ? int'(rom[m_pc]) : 0);
            chk("cycle_cnt", int'(cycle_cnt), (m_cnt > 65535) ? 65535 : m_cnt);
        end
        if (rst_n && trace_en && fetch_valid) trace.push_back(int'(pc_out));
    end

    // Driver tasks: all are entered and left at posedge+1.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic lut_write(input logic [3:0] a, input logic [9:0] d);
        lut_wr_en = 1'b1;
        lut_wr_addr = a;
        lut_wr_data = d;
        tick();
        lut_wr_en = 1'b0;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 1024; i++) rom[i] = 9'h000;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n;
        n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_timeout actual=done0 expected=done1 after %0d cycles", name, budget);
        end
    endtask

    task automatic chk_trace(input string name, input int exp[$]);
        chk({name, "_len"}, trace.size(), exp.size());
        for (int i = 0; i < exp.size() && i < trace.size(); i++) chk(name, trace[i], exp[i]);
        trace.delete();
    endtask

    initial begin
        clear_rom();
        #3;
        chk("rst_pc", int'(pc_out), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_valid", int'(fetch_valid), 0);
        chk("rst_instr", int'(instr_out), 0);
        chk("rst_cnt", int'(cycle_cnt), 0);
        tick();
        tick();
        rst_n = 1'b1;
        cmp_en = 1'b1;
        trace_en = 1'b1;
        tick();

        // Sequential run, halt at PC 5
        rom[5] = HALT;
        pulse_start();
        chk("seq_first_pc", int'(pc_out), 0);
        chk("seq_first_valid", int'(fetch_valid), 1);
        wait_done(40, "seq");
        chk("seq_cnt", int'(cycle_cnt), 5);
        chk("seq_pc", int'(pc_out), 5);
        chk_trace("seq_trace", '{0, 1, 2, 3, 4});

        // Absolute jump via lut[3]=40
        clear_rom();
        lut_write(4'd3, 10'd40);
        rom[2] = 9'h103;
        rom[40] = HALT;
        pulse_start();
        wait_done(40, "abs");
        chk("abs_cnt", int'(cycle_cnt), 3);
        chk("abs_pc", int'(pc_out), 40);
        chk_trace("abs_trace", '{0, 1, 2});

        // Relative backward loop, lut[1] = -2, taken twice
        clear_rom();
        lut_write(4'd1, 10'h3FE);
        rom[4] = 9'h181;
        rom[6] = HALT;
        loop_limit = 2;
        pulse_start();
        wait_done(60, "loop");
        chk("loop_cnt", int'(cycle_cnt), 12);
        chk_trace("loop_trace", '{0, 1, 2, 3, 4, 2, 3, 4, 2, 3, 4, 5});

        // Relative wrap to 1023 then 1023 -> 0
        clear_rom();
        lut_write(4'd2, 10'd1023);
        rom[0] = 9'h182;
        rom[1] = HALT;
        loop_limit = 1;
        pulse_start();
        wait_done(40, "wrap");
        chk("wrap_cnt", int'(cycle_cnt), 3);
        chk_trace("wrap_trace", '{0, 1023, 0});

        // Halt wins over a simultaneous jump
        clear_rom();
        rom[1] = HALT;
        force_halt_jmp = 1'b1;
        pulse_start();
        wait_done(40, "halt_jmp");
        chk("halt_jmp_pc", int'(pc_out), 1);
        chk("halt_jmp_cnt", int'(cycle_cnt), 1);
        force_halt_jmp = 1'b0;
        trace.delete();

        // Same-edge LUT write and read of entry 3 (old 40, new 50)
        clear_rom();
        rom[2] = 9'h103;
        rom[40] = 9'h103;
        rom[50] = HALT;
        pulse_start();
        tick();
        tick();
        lut_wr_en = 1'b1;
        lut_wr_addr = 4'd3;
        lut_wr_data = 10'd50;
        tick();
        lut_wr_en = 1'b0;
        chk("lutrw_old", int'(pc_out), 40);
        wait_done(40, "lutrw");
        chk("lutrw_new", int'(pc_out), 50);
        chk("lutrw_cnt", int'(cycle_cnt), 4);
        chk_trace("lutrw_trace", '{0, 1, 2, 40});

        // Asynchronous reset mid-run at PC 7
        clear_rom();
        pulse_start();
        for (int i = 0; i < 20 && pc_out != 10'd7; i++) tick();
        chk("pre_rst_pc", int'(pc_out), 7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_pc", int'(pc_out), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_valid", int'(fetch_valid), 0);
        chk("mid_rst_instr", int'(instr_out), 0);
        chk("mid_rst_cnt", int'(cycle_cnt), 0);
        tick();
        rst_n = 1'b1;
        trace.delete();
        tick();
        // Entry 3 must now be 0: a taken relative branch at PC 1 stays at PC 1
        rom[1] = 9'h183;
        rom[2] = HALT;
        loop_limit = 1;
        pulse_start();
        wait_done(40, "post_rst");
        chk("post_rst_cnt", int'(cycle_cnt), 3);
        chk_trace("post_rst_trace", '{0, 1, 1});

        // start ignored in RUN, honoured in DONE
        clear_rom();
        rom[3] = HALT;
        pulse_start();
        pulse_start();
        wait_done(40, "ignore");
        chk("ignore_cnt", int'(cycle_cnt), 3);
        chk("ignore_pc", int'(pc_out), 3);
        pulse_start();
        chk("restart_pc", int'(pc_out), 0);
        chk("restart_done", int'(done), 0);
        chk("restart_cnt", int'(cycle_cnt), 0);
        wait_done(40, "restart");
        chk("restart_final_cnt", int'(cycle_cnt), 3);
        trace_en = 1'b0;
        trace.delete();

        // Saturation: 70000 non-halt cycles
        clear_rom();
        pulse_start();
        repeat (70000) tick();
        chk("sat_cnt", int'(cycle_cnt), 65535);
        chk("sat_done", int'(done), 0);

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
